// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one shared 64-bit shift register, shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: multiplies computed in one step with a single hardware multiplier.
module muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int unsigned AW = 2 * XLEN;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        func3_q, func3_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              neg_q, neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand decode for the request presented in IDLE
    logic            is_div, a_signed, b_signed, a_neg, b_neg, req_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        is_div   = func3[2];
        a_signed = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) || (func3 == 3'b110);
        b_signed = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
        a_neg    = a_signed & op_a[XLEN-1];
        b_neg    = b_signed & op_b[XLEN-1];
        a_mag    = a_neg ? (XLEN'(0) - op_a) : op_a;
        b_mag    = b_neg ? (XLEN'(0) - op_b) : op_b;
        // remainder takes the dividend's sign; quotient and products take sign(a)^sign(b)
        req_neg  = (is_div && func3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !func3[0] && (op_a == XMIN) && (op_b == '1);
        if (div_zero) special_res = func3[1] ? op_a : '1;
        else          special_res = func3[1] ? '0 : XMIN;
    end

    // One iteration of each algorithm on the shared accumulator
    logic [XLEN-1:0] addend, sub_lo;
    logic [XLEN:0]   mul_sum, rem_sh;
    logic            rem_ge;
    logic [AW-1:0]   mul_step, div_step;

    always_comb begin
        addend   = acc_q[0] ? opnd_q : '0;
        mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, addend};
        mul_step = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = acc_q[AW-1:XLEN-1];
        rem_ge   = rem_sh >= {1'b0, opnd_q};
        sub_lo   = rem_sh[XLEN-1:0] - opnd_q;
        div_step = rem_ge ? {sub_lo, acc_q[XLEN-2:0], 1'b1} : {acc_q[AW-2:0], 1'b0};
    end

    // Sign fix-up and word select
    logic [AW-1:0]   prod_fix;
    logic [XLEN-1:0] div_word, div_fix, fix_res;

    always_comb begin
        prod_fix = neg_q ? (AW'(0) - acc_q) : acc_q;
        div_word = func3_q[1] ? acc_q[AW-1:XLEN] : acc_q[XLEN-1:0];
        div_fix  = neg_q ? (XLEN'(0) - div_word) : div_word;
        if (func3_q[2])               fix_res = div_fix;
        else if (func3_q[1:0] == 2'b00) fix_res = prod_fix[XLEN-1:0];
        else                          fix_res = prod_fix[AW-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        func3_d  = func3_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    func3_d = func3;
                    neg_d   = req_neg;
                    opnd_d  = b_mag;
                    cnt_d   = CNT_W'(XLEN);
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        acc_d   = {XLEN'(0), a_mag};
                        state_d = S_CALC;
`ifdef MULDIV_FAST_MUL_EN
                        if (!is_div) begin
                            acc_d   = AW'(a_mag) * AW'(b_mag);
                            state_d = S_FIX;
                        end
`endif
                    end
                end
            end
            S_CALC: begin
                acc_d = func3_q[2] ? div_step : mul_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort wins over everything and leaves the last result intact
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            func3_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            func3_q  <= func3_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign stall  = busy_q | (start & (state_q == S_IDLE));

endmodule
